// File: rtl/rx_control_unit.sv
// ---------------------------------------------------------------------------
// rx_control_unit
//   Receive-side sequencer for the UART/APB slave datapath. It qualifies a
//   detected start bit at mid-bit and then enables the bit timer for one
//   frame. It checks the stop bit, pulses the receive buffer load, and keeps
//   the data_ready / framing_error / overrun_error status flags.
//
// Ports
//   clk                 system clock
//   n_rst               asynchronous active-low reset
//   start_bit_detected  1-cycle pulse on a falling edge of the serial line
//   serial_in           synchronized serial line (start-bit validation)
//   bit_period          clocks per bit (config register)
//   packet_done         timer pulse: data bits + stop bit shifted in
//   stop_bit            stop-bit value held in the shift register
//   data_read           1-cycle pulse: RX data register was read
//   enable_timer        bit timer enable (low clears the timer)
//   load_buffer         1-cycle pulse: copy shift register to RX data reg
//   data_ready          RX data register holds unread data
//   framing_error       last frame had a 0 stop bit
//   overrun_error       a frame was loaded over unread data
//   rx_busy             sequencer is not idle (config writes blocked)
// ---------------------------------------------------------------------------
module rx_control_unit #(
    parameter int PERIOD_BITS = 14
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start_bit_detected,
    input  logic                   serial_in,
    input  logic [PERIOD_BITS-1:0] bit_period,
    input  logic                   packet_done,
    input  logic                   stop_bit,
    input  logic                   data_read,
    output logic                   enable_timer,
    output logic                   load_buffer,
    output logic                   data_ready,
    output logic                   framing_error,
    output logic                   overrun_error,
    output logic                   rx_busy
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        START_CHECK = 3'd1,
        RECEIVE     = 3'd2,
        STOP_CHECK  = 3'd3,
        LOAD        = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [PERIOD_BITS-1:0] half_cnt_q, half_cnt_d;
    logic [PERIOD_BITS-1:0] half_period;
    logic                   data_ready_q, data_ready_d;
    logic                   framing_q, framing_d;
    logic                   overrun_q, overrun_d;

    // Mid-bit sample point; a period of 0 or 1 still needs one check cycle.
    always_comb begin
        half_period = bit_period >> 1;
        if (half_period == '0) begin
            half_period = PERIOD_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            half_cnt_q   <= '0;
            data_ready_q <= 1'b0;
            framing_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_cnt_q   <= half_cnt_d;
            data_ready_q <= data_ready_d;
            framing_q    <= framing_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        half_cnt_d   = half_cnt_q;
        data_ready_d = data_ready_q;
        framing_d    = framing_q;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (start_bit_detected) begin
                    state_d    = START_CHECK;
                    half_cnt_d = PERIOD_BITS'(1);
                end
            end
            START_CHECK: begin
                if (half_cnt_q == half_period) begin
                    // Line back high at mid-bit means a glitch, not a start bit.
                    state_d = serial_in ? IDLE : RECEIVE;
                end else begin
                    half_cnt_d = half_cnt_q + PERIOD_BITS'(1);
                end
            end
            RECEIVE: begin
                if (packet_done) begin
                    state_d = STOP_CHECK;
                end
            end
            STOP_CHECK: begin
                framing_d = ~stop_bit;
                state_d   = stop_bit ? LOAD : IDLE;
            end
            LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A read that coincides with the load consumed the old data, so the
        // freshly loaded byte is not an overrun and stays pending.
        if (state_q == LOAD) begin
            data_ready_d = 1'b1;
            if (data_read) begin
                overrun_d = 1'b0;
            end else if (data_ready_q) begin
                overrun_d = 1'b1;
            end
        end else if (data_read) begin
            data_ready_d = 1'b0;
            overrun_d    = 1'b0;
        end
    end

    assign enable_timer  = (state_q == RECEIVE);
    assign load_buffer   = (state_q == LOAD);
    assign rx_busy       = (state_q != IDLE);
    assign data_ready    = data_ready_q;
    assign framing_error = framing_q;
    assign overrun_error = overrun_q;

endmodule

// File: tb/tb_rx_control_unit.sv
module tb_rx_control_unit;

    localparam int PB = 14;
    localparam int OP_FRAME = 0;
    localparam int OP_READ  = 1;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start_bit_detected = 1'b0;
    logic          serial_in = 1'b1;
    logic [PB-1:0] bit_period = PB'(10);
    logic          packet_done = 1'b0;
    logic          stop_bit = 1'b1;
    logic          data_read = 1'b0;
    logic          enable_timer, load_buffer, data_ready;
    logic          framing_error, overrun_error, rx_busy;

    rx_control_unit #(.PERIOD_BITS(PB)) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .start_bit_detected(start_bit_detected),
        .serial_in         (serial_in),
        .bit_period        (bit_period),
        .packet_done       (packet_done),
        .stop_bit          (stop_bit),
        .data_read         (data_read),
        .enable_timer      (enable_timer),
        .load_buffer       (load_buffer),
        .data_ready        (data_ready),
        .framing_error     (framing_error),
        .overrun_error     (overrun_error),
        .rx_busy           (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op;
        int bp;
        bit fs;      // false start
        bit sb;      // stop bit value
        bit rl;      // data_read during LOAD
        bit e_ready;
        bit e_fe;
        bit e_ovr;
        int e_load;
    } vec_t;

    typedef struct {
        bit ready;
        bit fe;
        bit ovr;
        int load;
        int idx;
    } exp_t;

    vec_t vecs[13];
    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one frame; returns the number of load_buffer pulses observed.
    task automatic run_frame(input int bp, input bit fs, input bit sb,
                             input bit rl, output int loads);
        int half;
        int n;
        bit en_seen;
        bit en_held;
        loads = 0;
        half  = ((bp >> 1) == 0) ? 1 : (bp >> 1);
        @(negedge clk);
        bit_period         = PB'(bp);
        serial_in          = 1'b0;
        start_bit_detected = 1'b1;
        @(negedge clk);
        start_bit_detected = 1'b0;
        if (fs) begin
            serial_in = 1'b1;
            en_seen   = 1'b0;
            for (int k = 0; k < half; k++) begin
                @(negedge clk);
                if (enable_timer) en_seen = 1'b1;
                if (load_buffer) loads++;
            end
            check("false_start_no_enable", int'(en_seen), 0);
            check("false_start_idle", int'(rx_busy), 0);
            $display("frame bp=%0d false_start: busy=%0d loads=%0d", bp, rx_busy, loads);
            return;
        end
        n = 0;
        while (!enable_timer && n < half + 4) begin
            @(negedge clk);
            n++;
        end
        check("start_latency", n, half);
        en_held = 1'b1;
        for (int k = 0; k < 9 * bp + 2; k++) begin
            @(negedge clk);
            if (!enable_timer) en_held = 1'b0;
        end
        check("enable_held", int'(en_held), 1);
        packet_done = 1'b1;
        stop_bit    = sb;
        @(negedge clk);                  // now STOP_CHECK
        packet_done = 1'b0;
        if (load_buffer) loads++;
        check("enable_drop", int'(enable_timer), 0);
        @(negedge clk);                  // LOAD if stop bit good
        if (load_buffer) loads++;
        check("load_at_2clk", int'(load_buffer), int'(sb));
        data_read = rl;
        @(negedge clk);
        data_read = 1'b0;
        stop_bit  = 1'b1;
        if (load_buffer) loads++;
        check("idle_after_frame", int'(rx_busy), 0);
        $display("frame bp=%0d sb=%0d rl=%0d: latency=%0d loads=%0d ready=%0d fe=%0d ovr=%0d",
                 bp, sb, rl, n, loads, data_ready, framing_error, overrun_error);
    endtask

    task automatic compare_flags(input exp_t e, input int loads);
        string s;
        s = $sformatf("v%0d", e.idx);
        check({s, "_data_ready"}, int'(data_ready), int'(e.ready));
        check({s, "_framing_error"}, int'(framing_error), int'(e.fe));
        check({s, "_overrun_error"}, int'(overrun_error), int'(e.ovr));
        check({s, "_load_count"}, loads, e.load);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   loads;
        int   n;

        //                op        bp  fs  sb  rl  rdy fe ovr load
        vecs[0]  = '{OP_FRAME, 10, 0, 1, 0, 1, 0, 0, 1};  // good frame
        vecs[1]  = '{OP_FRAME, 10, 1, 1, 0, 1, 0, 0, 0};  // false start
        vecs[2]  = '{OP_FRAME, 10, 0, 0, 0, 1, 1, 0, 0};  // framing error
        vecs[3]  = '{OP_FRAME, 10, 0, 1, 0, 1, 0, 1, 1};  // overrun, fe cleared
        vecs[4]  = '{OP_READ,   0, 0, 0, 0, 0, 0, 0, 0};  // read clears
        vecs[5]  = '{OP_FRAME,  1, 0, 1, 0, 1, 0, 0, 1};  // half forced to 1
        vecs[6]  = '{OP_FRAME,  7, 0, 1, 0, 1, 0, 1, 1};  // overrun again
        vecs[7]  = '{OP_READ,   0, 0, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{OP_FRAME,  4, 0, 1, 0, 1, 0, 0, 1};
        vecs[9]  = '{OP_FRAME,  6, 0, 1, 1, 1, 0, 0, 1};  // read in LOAD
        vecs[10] = '{OP_FRAME,  3, 1, 1, 0, 1, 0, 0, 0};  // false start
        vecs[11] = '{OP_FRAME,  2, 0, 0, 0, 1, 1, 0, 0};  // framing error
        vecs[12] = '{OP_FRAME,  0, 0, 1, 0, 1, 0, 1, 1};  // bp=0, overrun

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'({enable_timer, load_buffer, data_ready, framing_error, overrun_error, rx_busy}), 0);
        n_rst = 1'b1;
        @(negedge clk);
        $display("reset released: busy=%0d ready=%0d", rx_busy, data_ready);

        for (int i = 0; i < 13; i++) begin
            e = '{vecs[i].e_ready, vecs[i].e_fe, vecs[i].e_ovr, vecs[i].e_load, i};
            exp_q.push_back(e);
            if (vecs[i].op == OP_READ) begin
                @(negedge clk);
                data_read = 1'b1;
                @(negedge clk);
                data_read = 1'b0;
                loads = 0;
                $display("read pulse: ready=%0d ovr=%0d", data_ready, overrun_error);
            end else begin
                run_frame(vecs[i].bp, vecs[i].fs, vecs[i].sb, vecs[i].rl, loads);
            end
            e = exp_q.pop_front();
            compare_flags(e, loads);
        end

        // Reset in the middle of RECEIVE while flags are set
        @(negedge clk);
        bit_period         = PB'(10);
        serial_in          = 1'b0;
        start_bit_detected = 1'b1;
        @(negedge clk);
        start_bit_detected = 1'b0;
        n = 0;
        while (!enable_timer && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (30) @(negedge clk);
        check("pre_reset_receive", int'(enable_timer), 1);
        n_rst = 1'b0;
        #1;
        check("async_reset_outputs",
              int'({enable_timer, load_buffer, data_ready, framing_error, overrun_error, rx_busy}), 0);
        $display("mid-frame reset: en=%0d ready=%0d ovr=%0d", enable_timer, data_ready, overrun_error);
        @(negedge clk);
        n_rst = 1'b1;

        e = '{1'b1, 1'b0, 1'b0, 1, 99};
        exp_q.push_back(e);
        run_frame(10, 1'b0, 1'b1, 1'b0, loads);
        e = exp_q.pop_front();
        compare_flags(e, loads);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
